// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder datapath.
// State encoding, default operand width and a constant-friendly clog2.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ADD_WIDTH = 8;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: load a word, then shift right with zero
// fill so the serial output always presents the current LSB.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_par,
    output logic             o_ser
);

    logic [WIDTH-1:0] r_data;

    // Load wins over shift so a new operand set is never corrupted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_par;
        end else if (i_shift) begin
            r_data <= r_data >> 1;
        end
    end

    assign o_ser = r_data[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Feeds two operands LSB-first into a bit-serial adder after a one-cycle arm pulse.
// Define FEEDER_BACK_TO_BACK_EN to accept the next operand set during DONE.
module serial_operand_feeder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             a_bit,
    output logic             b_bit,
    output logic             cin_out,
    output logic             adder_rst,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int              CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

`ifdef FEEDER_BACK_TO_BACK_EN
    localparam bit BACK_TO_BACK = 1'b1;
`else
    localparam bit BACK_TO_BACK = 1'b0;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_cin;
    logic            r_bit_valid;
    logic            r_last_bit;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_shift;
    logic            w_ser_a;
    logic            w_ser_b;

    assign in_ready = (r_state == IDLE) || (BACK_TO_BACK && (r_state == DONE));
    assign w_accept = in_valid && in_ready;
    assign w_shift  = (r_state == SHIFT);

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_par   (op_a),
        .o_ser   (w_ser_a)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_par   (op_b),
        .o_ser   (w_ser_b)
    );

    // Status outputs are computed for the state being entered so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_cin       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last_bit  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= ARM;
                        r_count <= '0;
                        r_cin   <= op_cin;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    r_state     <= SHIFT;
                    r_bit_valid <= 1'b1;
                    r_last_bit  <= (LAST_IDX == '0);
                end
                SHIFT: begin
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_IDX) begin
                        r_state     <= DONE;
                        r_bit_valid <= 1'b0;
                        r_last_bit  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_last_bit <= ((r_count + CW'(1)) == LAST_IDX);
                    end
                end
                DONE: begin
                    if (BACK_TO_BACK && w_accept) begin
                        r_state <= ARM;
                        r_count <= '0;
                        r_cin   <= op_cin;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign a_bit     = r_bit_valid && w_ser_a;
    assign b_bit     = r_bit_valid && w_ser_b;
    assign cin_out   = r_cin;
    assign adder_rst = reset || (r_state == ARM);
    assign bit_valid = r_bit_valid;
    assign last_bit  = r_last_bit;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
